// File: rtl/fetch_pc_stage.sv
// Instruction-fetch stage: owns the PC, loads the IF/ID register, and sequences
// the post-reset boot bubble, stall, redirect/flush and halt detection.
module fetch_pc_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF,
  parameter logic [31:0] NOP_WORD  = 32'h0000_0000
) (
  input  logic        clk_in,
  input  logic        reset_in,
  input  logic [31:0] pc_plus4_in,
  input  logic [31:0] instr_data_in,
  input  logic        stall_in,
  input  logic        redirect_in,
  input  logic [31:0] redirect_pc_in,
  output logic [31:0] pc_out,
  output logic [31:0] if_id_instr_out,
  output logic [31:0] if_id_pc4_out,
  output logic        if_id_valid_out,
  output logic        halted_out
);

  typedef enum logic [1:0] {
    ST_BOOT   = 2'b00,
    ST_RUN    = 2'b01,
    ST_HALT   = 2'b10,
    ST_UNUSED = 2'b11
  } state_t;

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic [31:0] pc4_q;
  logic        valid_q;
  logic        halted_q;

  logic fetch_is_halt;
  assign fetch_is_halt = (instr_data_in == HALT_WORD);

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_q  <= ST_BOOT;
      pc_q     <= RESET_PC;
      instr_q  <= NOP_WORD;
      pc4_q    <= 32'h0000_0000;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      case (state_q)
        ST_BOOT: begin
          // One bubble cycle before the first real fetch; stall/redirect ignored.
          state_q  <= ST_RUN;
          pc_q     <= RESET_PC;
          instr_q  <= NOP_WORD;
          pc4_q    <= 32'h0000_0000;
          valid_q  <= 1'b0;
          halted_q <= 1'b0;
        end

        ST_RUN: begin
          if (redirect_in) begin
            // A redirect overrides a concurrent stall: the wrong-path fetch is dropped.
            pc_q    <= redirect_pc_in;
            instr_q <= NOP_WORD;
            pc4_q   <= 32'h0000_0000;
            valid_q <= 1'b0;
          end else if (!stall_in) begin
            instr_q <= instr_data_in;
            pc4_q   <= pc_plus4_in;
            valid_q <= 1'b1;
            if (fetch_is_halt) begin
              state_q  <= ST_HALT;
              halted_q <= 1'b1;
            end else begin
              pc_q <= pc_plus4_in;
            end
          end
        end

        ST_HALT: begin
          if (redirect_in) begin
            // The halt was on a mispredicted path; resume at the target.
            state_q  <= ST_RUN;
            halted_q <= 1'b0;
            pc_q     <= redirect_pc_in;
            instr_q  <= NOP_WORD;
            pc4_q    <= 32'h0000_0000;
            valid_q  <= 1'b0;
          end else if (!stall_in) begin
            instr_q <= NOP_WORD;
            pc4_q   <= 32'h0000_0000;
            valid_q <= 1'b0;
          end
        end

        default: begin
          state_q  <= ST_BOOT;
          pc_q     <= RESET_PC;
          instr_q  <= NOP_WORD;
          pc4_q    <= 32'h0000_0000;
          valid_q  <= 1'b0;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

  assign pc_out          = pc_q;
  assign if_id_instr_out = instr_q;
  assign if_id_pc4_out   = pc4_q;
  assign if_id_valid_out = valid_q;
  assign halted_out      = halted_q;

endmodule

// File: tb/tb_fetch_pc_stage.sv
// Directed bench for fetch_pc_stage: a behavioural fetch model checked every
// cycle, plus literal expectations taken from the fetch sequence by hand.
module tb_fetch_pc_stage;

  localparam logic [31:0] HALT_W = 32'hFFFF_FFFF;
  localparam logic [31:0] NOP_W  = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset_in = 1'b1;
  logic [31:0] pc_plus4_in;
  logic [31:0] instr_data_in;
  logic        stall_in = 1'b0;
  logic        redirect_in = 1'b0;
  logic [31:0] redirect_pc_in = 32'h0;
  logic [31:0] pc_out;
  logic [31:0] if_id_instr_out;
  logic [31:0] if_id_pc4_out;
  logic        if_id_valid_out;
  logic        halted_out;

  always #5 clk = ~clk;

  fetch_pc_stage dut (
    .clk_in          (clk),
    .reset_in        (reset_in),
    .pc_plus4_in     (pc_plus4_in),
    .instr_data_in   (instr_data_in),
    .stall_in        (stall_in),
    .redirect_in     (redirect_in),
    .redirect_pc_in  (redirect_pc_in),
    .pc_out          (pc_out),
    .if_id_instr_out (if_id_instr_out),
    .if_id_pc4_out   (if_id_pc4_out),
    .if_id_valid_out (if_id_valid_out),
    .halted_out      (halted_out)
  );

  // Instruction memory contents used by the scenarios.
  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    case (a)
      32'h0000_0000: mem_rd = 32'h2008_0005;
      32'h0000_0004: mem_rd = 32'h2009_000A;
      32'h0000_0008: mem_rd = 32'h0109_5020;
      32'h0000_000C: mem_rd = 32'h3C01_1234;
      32'h0000_0010: mem_rd = HALT_W;
      32'h0000_0040: mem_rd = 32'h2010_0040;
      32'hFFFF_FFFC: mem_rd = 32'h2011_FFFC;
      default:       mem_rd = {16'hA5A5, a[15:0]};
    endcase
  endfunction

  // The bench plays the PC+4 adder and the combinational instruction memory.
  assign pc_plus4_in   = pc_out + 32'd4;
  assign instr_data_in = mem_rd(pc_out);

  int vec_cnt = 0;
  int err_cnt = 0;
  bit chk_en  = 1'b0;

  // Model state: mode 0 = boot bubble pending, 1 = fetching, 2 = halted.
  int          m_mode;
  logic [31:0] m_pc, m_instr, m_pc4;
  bit          m_valid, m_pc4_known;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("pc", pc_out, m_pc);
      chk("instr", if_id_instr_out, m_instr);
      chk("valid", {31'b0, if_id_valid_out}, {31'b0, m_valid});
      chk("halted", {31'b0, halted_out}, {31'b0, m_mode == 2});
      if (m_valid || m_pc4_known) chk("pc4", if_id_pc4_out, m_pc4);
    end
  end

  task automatic step(input logic rst, input logic st, input logic rd, input logic [31:0] rpc);
    logic [31:0] w;
    reset_in       = rst;
    stall_in       = st;
    redirect_in    = rd;
    redirect_pc_in = rpc;
    @(posedge clk);
    if (rst) begin
      m_mode = 0; m_pc = 32'h0; m_instr = NOP_W; m_pc4 = 32'h0;
      m_valid = 0; m_pc4_known = 1;
    end else if (m_mode == 0) begin
      m_mode = 1; m_instr = NOP_W; m_valid = 0; m_pc4_known = 0;
    end else if (rd) begin
      m_mode = 1; m_pc = rpc; m_instr = NOP_W; m_pc4 = 32'h0;
      m_valid = 0; m_pc4_known = 1;
    end else if (!st) begin
      if (m_mode == 1) begin
        w = mem_rd(m_pc);
        m_instr = w; m_pc4 = m_pc + 32'd4; m_valid = 1; m_pc4_known = 1;
        if (w == HALT_W) m_mode = 2;
        else m_pc = m_pc + 32'd4;
      end else begin
        m_instr = NOP_W; m_valid = 0; m_pc4_known = 0;
      end
    end
    if (rst) chk_en = 1'b1;
    @(negedge clk);
    #1;
    $display("step rst=%0b stall=%0b redir=%0b rpc=%h -> pc=%h instr=%h pc4=%h v=%0b h=%0b",
             rst, st, rd, rpc, pc_out, if_id_instr_out, if_id_pc4_out, if_id_valid_out, halted_out);
  endtask

  task automatic norm();
    step(1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    // 1: reset, boot bubble, sequential fetch
    step(1, 0, 0, 32'h0);
    step(1, 0, 0, 32'h0);
    chk("rst_pc", pc_out, 32'h0);
    chk("rst_valid", {31'b0, if_id_valid_out}, 32'h0);
    step(0, 0, 0, 32'h0);
    chk("boot_pc", pc_out, 32'h0);
    chk("boot_valid", {31'b0, if_id_valid_out}, 32'h0);
    norm();
    chk("f0_pc", pc_out, 32'h4);
    chk("f0_instr", if_id_instr_out, 32'h2008_0005);
    chk("f0_pc4", if_id_pc4_out, 32'h4);
    norm();
    chk("f1_instr", if_id_instr_out, 32'h2009_000A);
    chk("f1_pc", pc_out, 32'h8);
    // 2: three stalled cycles at pc 8
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, 32'h0);
      chk("stall_pc", pc_out, 32'h8);
      chk("stall_instr", if_id_instr_out, 32'h2009_000A);
    end
    norm();
    chk("f2_instr", if_id_instr_out, 32'h0109_5020);
    chk("f2_pc4", if_id_pc4_out, 32'hC);
    // 3: redirect beats stall
    step(0, 1, 1, 32'h0000_0040);
    chk("rd_pc", pc_out, 32'h40);
    chk("rd_valid", {31'b0, if_id_valid_out}, 32'h0);
    chk("rd_instr", if_id_instr_out, NOP_W);
    norm();
    chk("f40_instr", if_id_instr_out, 32'h2010_0040);
    chk("f40_pc4", if_id_pc4_out, 32'h44);
    // 4: wrap through the top of the address space
    step(0, 0, 1, 32'hFFFF_FFFC);
    norm();
    chk("wrap_pc", pc_out, 32'h0);
    chk("wrap_pc4", if_id_pc4_out, 32'h0);
    chk("wrap_valid", {31'b0, if_id_valid_out}, 32'h1);
    for (int i = 0; i < 4; i++) norm();
    chk("pre_halt_pc", pc_out, 32'h10);
    // 5: halt word at 0x10
    norm();
    chk("halt_instr", if_id_instr_out, HALT_W);
    chk("halt_pc", pc_out, 32'h10);
    chk("halt_flag", {31'b0, halted_out}, 32'h1);
    norm();
    norm();
    chk("halt_bub_valid", {31'b0, if_id_valid_out}, 32'h0);
    chk("halt_bub_pc", pc_out, 32'h10);
    step(0, 1, 0, 32'h0);
    step(0, 0, 1, 32'h0000_0020);
    chk("unhalt_pc", pc_out, 32'h20);
    chk("unhalt_flag", {31'b0, halted_out}, 32'h0);
    norm();
    chk("f20_instr", if_id_instr_out, 32'hA5A5_0020);
    // unaligned redirect passes through unchanged
    step(0, 0, 1, 32'h0000_0043);
    chk("unal_pc", pc_out, 32'h43);
    norm();
    chk("unal_pc4", if_id_pc4_out, 32'h47);
    // 6: reset during halt, during stall, and with redirect
    step(0, 0, 1, 32'h0000_0010);
    norm();
    chk("halt2_flag", {31'b0, halted_out}, 32'h1);
    step(1, 0, 0, 32'h0);
    chk("rst_halt_pc", pc_out, 32'h0);
    chk("rst_halt_flag", {31'b0, halted_out}, 32'h0);
    step(0, 1, 1, 32'h0000_0080);
    chk("boot2_pc", pc_out, 32'h0);
    chk("boot2_valid", {31'b0, if_id_valid_out}, 32'h0);
    norm();
    chk("boot2_f0", if_id_instr_out, 32'h2008_0005);
    step(0, 1, 0, 32'h0);
    step(1, 1, 0, 32'h0);
    chk("rst_stall_pc", pc_out, 32'h0);
    chk("rst_stall_valid", {31'b0, if_id_valid_out}, 32'h0);
    step(0, 0, 0, 32'h0);
    norm();
    norm();
    step(1, 0, 1, 32'h0000_0040);
    chk("rst_rd_pc", pc_out, 32'h0);
    step(0, 0, 0, 32'h0);
    norm();
    chk("final_pc", pc_out, 32'h4);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
